ff_affine_conv_255: RTL

//  Downstream consumer of ff_inv_seq_255. Converts a projective point (X:Y:Z) to affine

---
 rtl/ff_affine_conv_255_if.sv | 15 +
 rtl/ff_affine_conv_255.sv | 97 +++++++++
 2 files changed

// File: rtl/ff_affine_conv_255_if.sv
// ff_affine_conv_255_if: bus between the inverter-side producer and the affine converter
//   master : drives x_in, y_in, zinv, zinv_valid; observes x_aff, y_aff, busy, valid
//   slave  : the converter; receives the projective point and Z^-1 and returns affine x/y
interface ff_affine_conv_255_if #(parameter int W = 255);
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic [W-1:0] zinv;
    logic         zinv_valid;
    logic [W-1:0] x_aff;
    logic [W-1:0] y_aff;
    logic         busy;
    logic         valid;
    modport master (output x_in, y_in, zinv, zinv_valid, input x_aff, y_aff, busy, valid);
    modport slave  (input x_in, y_in, zinv, zinv_valid, output x_aff, y_aff, busy, valid);
endinterface

// File: rtl/ff_affine_conv_255.sv
// ff_affine_conv_255: projective (X:Y:Z) to affine (X*Zinv, Y*Zinv) mod p, p = 2^255-19
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of ff_affine_conv_255_if
//          x_in/y_in/zinv captured (and reduced once) on the rising edge of zinv_valid,
//          x_aff/y_aff affine results (< P), busy during the two multiplies,
//          valid while the result is held (until zinv_valid falls)
//   One bit-serial MSB-first interleaved modular multiplier is used for X, then Y.
module ff_affine_conv_255 #(
    parameter int         W = 255,
    parameter logic [W:0] P = {1'b0, {(W-5){1'b1}}, 5'b01101}
) (
    input logic               clk,
    input logic               rst,
    ff_affine_conv_255_if.slave bus
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, MUL_X, MUL_Y, DONE} state_t;
    state_t        state, state_next;
    logic [W-1:0]  a, ya, b, x_aff, y_aff;
    logic [W:0]    acc, t1, t2, t3, t4;
    logic [CW-1:0] cnt;
    logic          vq, armed, zv, start, last, busy;
    // Single conditional subtract is enough: any W-bit value is below 2P.
    function automatic logic [W-1:0] red(input logic [W-1:0] v);
        return ({1'b0, v} >= P) ? W'({1'b0, v} - P) : v;
    endfunction
    assign zv    = bus.zinv_valid;
    // armed: zinv_valid must be seen low after reset, so a level held high through
    // reset release is not mistaken for a fresh edge.
    assign start = zv & ~vq & armed;
    assign last  = (cnt == '0);
    assign busy  = (state == MUL_X) || (state == MUL_Y);
    assign bus.busy  = busy;
    assign bus.valid = (state == DONE);
    assign bus.x_aff = x_aff;
    assign bus.y_aff = y_aff;
    // One multiplier step; acc < P keeps every intermediate below 2P.
    always_comb begin
        t1 = acc << 1;
        t2 = (t1 >= P) ? t1 - P : t1;
        t3 = a[cnt] ? t2 + {1'b0, b} : t2;
        t4 = (t3 >= P) ? t3 - P : t3;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? MUL_X : IDLE;
            MUL_X:   state_next = !zv ? IDLE : (last ? MUL_Y : MUL_X);
            MUL_Y:   state_next = !zv ? IDLE : (last ? DONE : MUL_Y);
            DONE:    state_next = !zv ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vq    <= 1'b0;
            armed <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            a     <= '0;
            ya    <= '0;
            b     <= '0;
            x_aff <= '0;
            y_aff <= '0;
        end else begin
            vq    <= zv;
            armed <= armed | ~zv;
            if (state == IDLE && start) begin
                a   <= red(bus.x_in);
                ya  <= red(bus.y_in);
                b   <= red(bus.zinv);
                acc <= '0;
                cnt <= CW'(W-1);
            end else if (busy && zv) begin
                if (last) begin
                    // Finish this coordinate and rearm the multiplier for Y.
                    acc <= '0;
                    cnt <= CW'(W-1);
                    a   <= ya;
                    if (state == MUL_X) x_aff <= t4[W-1:0];
                    else                y_aff <= t4[W-1:0];
                end else begin
                    acc <= t4;
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule
